// File: rtl/ccu25_pkg.sv
// Shared definitions for the CCU25 slow-control bus arbiter: FSM state
// encoding, bus word field positions and a helper that packs a bus word.
package ccu25_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 24;
  localparam int WORD_W  = 32;

  // Bus word layout: {write, addr[6:0], data[23:0]}
  localparam int WR_BIT  = 31;
  localparam int ADDR_HI = 30;
  localparam int ADDR_LO = 24;
  localparam int DATA_HI = 23;
  localparam int DATA_LO = 0;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_STROBE   = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_TURN     = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SETUP    = ST_SETUP,
    STROBE   = ST_STROBE,
    WAIT_ACK = ST_WAIT_ACK,
    DONE     = ST_DONE,
    TURN     = ST_TURN
  } state_t;

  function automatic logic [WORD_W-1:0] pack_word(input logic              wr,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] data);
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[WR_BIT]          = wr;
    w[ADDR_HI:ADDR_LO] = addr;
    w[DATA_HI:DATA_LO] = data;
    return w;
  endfunction

endpackage

// File: rtl/ccu25_bus_arbiter_if.sv
// Requester handshake plus CCU25 pad-side bus signals of the arbiter.
// slave = arbiter side, master = requesters/pads side.
interface ccu25_bus_arbiter_if import ccu25_pkg::*; #(
  parameter int NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_grant;
  logic [NUM_REQ-1:0]             req_done;
  logic                           rsp_err;
  logic [DATA_W-1:0]              rsp_rdata;
  logic                           busy;

  logic [WORD_W-1:0]              ccu25_data_o;
  logic                           ccu25_data_oe;
  logic [WORD_W-1:0]              ccu25_data_i;
  logic                           ccu25_strobe_in;
  logic                           ccu25_strobe_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, ccu25_data_i, ccu25_strobe_out,
    output req_grant, req_done, rsp_err, rsp_rdata, busy,
           ccu25_data_o, ccu25_data_oe, ccu25_strobe_in
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, ccu25_data_i, ccu25_strobe_out,
    input  req_grant, req_done, rsp_err, rsp_rdata, busy,
           ccu25_data_o, ccu25_data_oe, ccu25_strobe_in
  );

endinterface

// File: rtl/ccu25_rr_arbiter.sv
// Round-robin pick: first request at/after the pointer, wrapping.
// The pointer moves past the winner only when the pick is taken.
module ccu25_rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               take_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] hi_mask, masked, cand;

  assign any_o = |req_i;

  // Masked pick (at/after pointer) wins; otherwise wrap to the unmasked pick.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) hi_mask[i] = (i >= int'(ptr_q));
    masked    = req_i & hi_mask;
    cand      = (|masked) ? masked : req_i;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        gnt_oh_o    = '0;
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = IDX_W'(i);
      end
    end
  end

  // Next pointer: one past the winner, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    ptr_d = ptr_q;
    if (take_i)
      ptr_d = (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ccu25_bus_arbiter.sv
// Shares the CCU25 slow-control bus between NUM_REQ requesters.
// Sequence per transaction: IDLE(grant) -> SETUP -> STROBE -> WAIT_ACK -> DONE -> TURN.
// Optional ack timeout enabled by defining CCU25_ARB_TIMEOUT_EN.
module ccu25_bus_arbiter import ccu25_pkg::*; #(
  parameter int NUM_REQ        = 3,
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  ccu25_bus_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 16;

  state_t             st_q;
  logic               ack_s1_q, ack_s2_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WORD_W-1:0]  word_q;
  logic               wr_q;
  logic [NUM_REQ-1:0] own_q;
  logic [NUM_REQ-1:0] done_q;
  logic               oe_q;
  logic               stb_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               take;

  // Upper pad bits carry nothing the arbiter needs.
  logic unused_hi;
  assign unused_hi = ^bus.ccu25_data_i[WORD_W-1:DATA_W];

  ccu25_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.req_valid),
    .take_i    (take),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  // A grant needs an idle bus and a released ack, so a stuck ack from the
  // previous slave cannot be mistaken for the next transaction's ack.
  assign take          = rst_n && (st_q == IDLE) && arb_any && !ack_s2_q;
  assign bus.req_grant = take ? arb_oh : '0;

  assign bus.busy            = (st_q != IDLE);
  assign bus.ccu25_data_oe   = oe_q;
  assign bus.ccu25_data_o    = oe_q ? word_q : '0;
  assign bus.ccu25_strobe_in = stb_q;
  assign bus.req_done        = done_q;
  assign bus.rsp_rdata       = rdata_q;

`ifdef CCU25_ARB_TIMEOUT_EN
  logic err_q;
  assign bus.rsp_err = err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign bus.rsp_err = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous CCU25 ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
    end else begin
      ack_s1_q <= bus.ccu25_strobe_out;
      ack_s2_q <= ack_s1_q;
    end
  end

  // Transaction sequencer with registered bus/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      own_q   <= '0;
      done_q  <= '0;
      oe_q    <= 1'b0;
      stb_q   <= 1'b0;
      rdata_q <= '0;
`ifdef CCU25_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (st_q)
        IDLE: begin
          done_q <= '0;
          if (take) begin
            own_q  <= arb_oh;
            wr_q   <= bus.req_write[arb_idx];
            word_q <= pack_word(bus.req_write[arb_idx], bus.req_addr[arb_idx],
                                bus.req_wdata[arb_idx]);
            oe_q   <= 1'b1;
            cnt_q  <= '0;
            st_q   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
            cnt_q <= '0;
            stb_q <= 1'b1;
            st_q  <= STROBE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STROBE: begin
          if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
            cnt_q <= '0;
            stb_q <= 1'b0;
            oe_q  <= wr_q;  // reads release the bus so the CCU25 can drive it
            st_q  <= WAIT_ACK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_s2_q) begin
            if (!wr_q) rdata_q <= bus.ccu25_data_i[DATA_HI:DATA_LO];
            oe_q   <= 1'b0;
            done_q <= own_q;
`ifdef CCU25_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            st_q   <= DONE;
          end
`ifdef CCU25_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rdata_q <= '0;
            oe_q    <= 1'b0;
            done_q  <= own_q;
            err_q   <= 1'b1;
            st_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          done_q <= '0;
          st_q   <= TURN;
        end
        TURN:    st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu25_bus_arbiter.sv
// Directed bench for ccu25_bus_arbiter (NUM_REQ=3, SETUP=1, STROBE=2).
// Cycle 0 of each transaction is the cycle in which req_grant is visible.
module tb_ccu25_bus_arbiter;
  import ccu25_pkg::*;

  localparam int NR = 3;
  localparam int NH = 1200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccu25_bus_arbiter_if #(.NUM_REQ(NR)) bus ();

  ccu25_bus_arbiter #(
    .NUM_REQ(NR), .SETUP_CYCLES(1), .STROBE_CYCLES(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [NR-1:0] gnt_h  [NH];
  logic [NR-1:0] done_h [NH];
  logic          oe_h   [NH];
  logic          stb_h  [NH];
  logic          busy_h [NH];
  logic          err_h  [NH];
  logic [31:0]   dat_h  [NH];
  logic [23:0]   rd_h   [NH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs cycles 0..ncyc, recording outputs at each negedge. Requesters drop
  // req_valid once granted. The CCU25 model raises ack dly+1 cycles after the
  // first strobe-low cycle (dly<0: never) and releases it after done unless hold.
  task automatic run(input int dly, input bit hold, input logic [23:0] rd, input int ncyc);
    int tmr;
    tmr = -1;
    for (int k = 0; k <= ncyc; k++) begin
      @(negedge clk);
      gnt_h[k]  = bus.req_grant;
      done_h[k] = bus.req_done;
      oe_h[k]   = bus.ccu25_data_oe;
      stb_h[k]  = bus.ccu25_strobe_in;
      busy_h[k] = bus.busy;
      err_h[k]  = bus.rsp_err;
      dat_h[k]  = bus.ccu25_data_o;
      rd_h[k]   = bus.rsp_rdata;
      tick();
      bus.req_valid = bus.req_valid & ~gnt_h[k];
      if (k > 0 && stb_h[k-1] && !stb_h[k]) tmr = dly;
      else if (tmr > 0) tmr--;
      if (done_h[k] != '0 && !hold) tmr = -1;
      bus.ccu25_strobe_out = (tmr == 0);
      bus.ccu25_data_i     = (tmr == 0) ? {8'h00, rd} : 32'h0;
    end
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int cnt;
    logic all1;

    bus.req_valid        = '0;
    bus.req_write        = '0;
    bus.req_addr         = '0;
    bus.req_wdata        = '0;
    bus.ccu25_data_i     = '0;
    bus.ccu25_strobe_out = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst busy",   32'(bus.busy), 32'h0);
    chk("rst oe",     32'(bus.ccu25_data_oe), 32'h0);
    chk("rst strobe", 32'(bus.ccu25_strobe_in), 32'h0);
    chk("rst data_o", bus.ccu25_data_o, 32'h0);
    chk("rst done",   32'(bus.req_done), 32'h0);
    chk("rst rdata",  32'(bus.rsp_rdata), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // 1: write on req 0, ack 5 cycles after strobe falls
    bus.req_write    = 3'b001;
    bus.req_addr[0]  = 7'h12;
    bus.req_wdata[0] = 24'h00ABCD;
    bus.req_valid    = 3'b001;
    run(4, 1'b0, 24'h0, 16);
    chk("t1 grant",   32'(gnt_h[0]), 32'h1);
    chk("t1 word",    dat_h[1], 32'h9200ABCD);
    all1 = 1'b1;
    for (int k = 1; k <= 11; k++) all1 &= oe_h[k];
    chk("t1 oe held", 32'(all1), 32'h1);
    cnt = 0;
    for (int k = 0; k <= 16; k++) if (stb_h[k]) cnt++;
    chk("t1 strobe width", 32'(cnt), 32'd2);
    chk("t1 strobe start", {30'h0, stb_h[1], stb_h[2]}, 32'h1);
    chk("t1 no early done", 32'(done_h[11]), 32'h0);
    chk("t1 done",    32'(done_h[12]), 32'h1);
    chk("t1 err",     32'(err_h[12]), 32'h0);
    chk("t1 oe done", 32'(oe_h[12]), 32'h0);
    chk("t1 data0",   dat_h[12], 32'h0);
    chk("t1 turn",    32'(busy_h[13]), 32'h1);
    chk("t1 idle",    32'(busy_h[14]), 32'h0);

    // 2: read on req 1 (pointer now 1)
    bus.req_write[1] = 1'b0;
    bus.req_addr[1]  = 7'h05;
    bus.req_valid    = 3'b010;
    run(4, 1'b0, 24'h123456, 16);
    chk("t2 grant",      32'(gnt_h[0]), 32'h2);
    chk("t2 oe strobe",  32'(oe_h[3]), 32'h1);
    chk("t2 oe wait",    32'(oe_h[4]), 32'h0);
    chk("t2 data wait",  dat_h[4], 32'h0);
    chk("t2 done",       32'(done_h[12]), 32'h2);
    chk("t2 rdata",      32'(rd_h[12]), 32'h123456);
    chk("t2 rdata held", 32'(rd_h[16]), 32'h123456);

    // 4: read on req 1, no ack ever
    bus.req_addr[1] = 7'h33;
    bus.req_valid   = 3'b010;
`ifdef CCU25_ARB_TIMEOUT_EN
    run(-1, 1'b0, 24'h0, 72);
    chk("t4 grant",   32'(gnt_h[0]), 32'h2);
    chk("t4 oe wait", 32'(oe_h[10]), 32'h0);
    chk("t4 no early done", 32'(done_h[67]), 32'h0);
    chk("t4 done",    32'(done_h[68]), 32'h2);
    chk("t4 err",     32'(err_h[68]), 32'h1);
    chk("t4 rdata0",  32'(rd_h[68]), 32'h0);
`else
    run(-1, 1'b0, 24'h0, 1100);
    chk("t4 grant",   32'(gnt_h[0]), 32'h2);
    chk("t4 oe wait", 32'(oe_h[10]), 32'h0);
    cnt = 0;
    for (int k = 0; k <= 1100; k++) if (done_h[k] != '0) cnt++;
    chk("t4 no done", 32'(cnt), 32'h0);
    chk("t4 busy",    32'(busy_h[1100]), 32'h1);
`endif

    // 3: all three pending from pointer 0, then 3'b101
    rst_pulse();
    bus.req_write = 3'b111;
    bus.req_valid = 3'b111;
    run(4, 1'b0, 24'h0, 46);
    chk("t3 grant0",  32'(gnt_h[0]),  32'h1);
    chk("t3 turn",    {30'h0, busy_h[13], 1'b0} | 32'(gnt_h[13]), 32'h2);
    chk("t3 ack gap", 32'(gnt_h[14]), 32'h0);
    chk("t3 grant1",  32'(gnt_h[15]), 32'h2);
    chk("t3 grant2",  32'(gnt_h[30]), 32'h4);
    cnt = 0;
    for (int k = 0; k <= 46; k++) if (gnt_h[k] != '0) cnt++;
    chk("t3 grant count", 32'(cnt), 32'd3);
    bus.req_valid = 3'b101;
    run(4, 1'b0, 24'h0, 31);
    chk("t3b grant0", 32'(gnt_h[0]),  32'h1);
    chk("t3b grant2", 32'(gnt_h[15]), 32'h4);
    cnt = 0;
    for (int k = 0; k <= 31; k++) if (gnt_h[k] != '0) cnt++;
    chk("t3b grant count", 32'(cnt), 32'd2);

    // 5: reset during STROBE, then regrant of still-pending req 2
    rst_pulse();
    bus.req_write[2] = 1'b1;
    bus.req_addr[2]  = 7'h44;
    bus.req_wdata[2] = 24'h5A5A5A;
    bus.req_valid    = 3'b100;
    run(-1, 1'b0, 24'h0, 2);
    chk("t5 in strobe", {30'h0, busy_h[2], stb_h[2]}, 32'h3);
    #2;
    rst_n = 1'b0;
    bus.req_valid = 3'b100;
    #1;
    chk("t5 async strobe", 32'(bus.ccu25_strobe_in), 32'h0);
    chk("t5 async oe",     32'(bus.ccu25_data_oe), 32'h0);
    chk("t5 async busy",   32'(bus.busy), 32'h0);
    chk("t5 no done",      32'(bus.req_done), 32'h0);
    chk("t5 no grant",     32'(bus.req_grant), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    run(4, 1'b1, 24'h0, 16);
    chk("t5 regrant", 32'(gnt_h[0]),  32'h4);
    chk("t5 done",    32'(done_h[12]), 32'h4);

    // 6: ack stuck high, req 0 waits; grant on third edge after the fall
    bus.req_valid = 3'b001;
    all1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      all1 &= (bus.req_grant == '0);
      tick();
    end
    chk("t6 held off", 32'(all1), 32'h1);
    bus.ccu25_strobe_out = 1'b0;
    @(negedge clk);
    chk("t6 fall+0", 32'(bus.req_grant), 32'h0);
    tick();
    @(negedge clk);
    chk("t6 fall+1", 32'(bus.req_grant), 32'h0);
    tick();
    @(negedge clk);
    chk("t6 fall+2", 32'(bus.req_grant), 32'h1);
    tick();
    bus.req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
